test_callee: RTL and testbench

FL operation-centric callee: the responding end of the en/rdy call interface. It holds a queue of scripted transactions, each an expected call message, a return message and a ready delay. It asserts `rdy` when the head entry's delay expires, presents the head return message combinationally, and checks the incoming call message on the accepting edge. It sits in FL test benches, opposite a caller or in place of a DUT's downstream unit.

---
 rtl/test_callee_pkg.sv | 29 ++
 rtl/test_callee_queue.sv | 61 ++++++
 rtl/test_callee.sv | 137 +++++++++++++
 tb/tb_test_callee.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/test_callee_pkg.sv
// Shared types for the scripted en/rdy callee: FSM states, default entry
// layout and a saturating counter helper.
package test_callee_pkg;

  localparam int DEF_MSG_W   = 32;
  localparam int DEF_DELAY_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY
  } t_callee_state;

  // Default-width scripted entry; the top builds the same layout from its
  // own message types and delay width.
  typedef struct packed {
    logic [DEF_MSG_W-1:0]   exp_call;
    logic [DEF_MSG_W-1:0]   ret;
    logic [DEF_DELAY_W-1:0] delay;
  } t_callee_entry;

  // 16-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/test_callee_queue.sv
// Circular buffer of scripted entries. Push and pop on the same edge are
// both honoured; pushing into a queue emptied by that pop lands at the new
// read pointer, so it becomes the head on that edge.
module test_callee_queue
  import test_callee_pkg::*;
#(
  parameter int  p_depth = 32,
  parameter type t_entry = t_callee_entry
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  t_entry                     push_data_i,
  input  logic                       pop_i,
  output t_entry                     head_o,
  output t_entry                     next_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(p_depth):0]   count_o
);

  localparam int PW = $clog2(p_depth);

  t_entry          mem_q [p_depth];
  logic [PW-1:0]   rd_q, wr_q;
  logic [PW:0]     cnt_q;
  logic            push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(p_depth));
  assign count_o = cnt_q;
  assign pop_ok  = pop_i & ~empty_o;
  // A full queue still accepts a push when the same edge frees a slot.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign head_o  = mem_q[rd_q];
  assign next_o  = mem_q[rd_q + PW'(1)];

  // Pointer and occupancy update; reset drops everything, including a
  // push presented during the reset cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PW'(1);
      if (pop_ok)  rd_q <= rd_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/test_callee.sv
// Scripted responding end of an en/rdy call interface. Each queued entry
// holds the expected call, the return message and a ready delay; calls are
// checked on the accepting edge and every violation bumps error_count.
module test_callee
  import test_callee_pkg::*;
#(
  parameter type t_call_msg   = logic [31:0],
  parameter type t_ret_msg    = logic [31:0],
  parameter int  p_depth      = 32,
  parameter int  p_delay_bits = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  t_call_msg               call_msg_i,
  output t_ret_msg                ret_msg_o,
  input  logic                    en_i,
  output logic                    rdy_o,
  output logic                    done_o,
  output logic [15:0]             error_count_o,
  input  logic                    push_i,
  input  t_call_msg               push_exp_call_i,
  input  t_ret_msg                push_ret_i,
  input  logic [p_delay_bits-1:0] push_delay_i
);

  localparam int PW = $clog2(p_depth);

  typedef struct packed {
    t_call_msg               exp_call;
    t_ret_msg                ret;
    logic [p_delay_bits-1:0] delay;
  } t_entry;

  t_callee_state           state_q, state_d;
  logic [p_delay_bits-1:0] cnt_q, cnt_d;
  logic [15:0]             err_q;

  t_entry      q_head, q_next, push_entry, next_entry;
  logic        q_full, q_empty;
  logic [PW:0] q_count;
  logic        fire, stall, mismatch, overflow, push_ok, next_avail;
  logic [1:0]  err_inc;

  assign push_entry = '{exp_call: push_exp_call_i, ret: push_ret_i, delay: push_delay_i};

  test_callee_queue #(
    .p_depth (p_depth),
    .t_entry (t_entry)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_i),
    .push_data_i (push_entry),
    .pop_i       (fire),
    .head_o      (q_head),
    .next_o      (q_next),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  // rdy/ret_msg decode only registered state, so a caller may sample the
  // return message before deciding to raise en.
  assign rdy_o     = (state_q == ST_READY);
  assign ret_msg_o = rdy_o ? q_head.ret : 'x;
  assign done_o    = (state_q == ST_IDLE) & q_empty;

  assign fire      = en_i & rdy_o;
  assign stall     = en_i & ~rdy_o;
  assign mismatch  = fire & (call_msg_i != q_head.exp_call);
  assign overflow  = push_i & q_full & ~fire;
  assign push_ok   = push_i & (~q_full | fire);

  // Head after a pop: the second stored entry, or a same-edge push when the
  // pop drains the queue.
  assign next_avail = (q_count > (PW+1)'(1)) | push_ok;
  assign next_entry = (q_count > (PW+1)'(1)) ? q_next : push_entry;

  assign err_inc = {1'b0, stall | mismatch} + {1'b0, overflow};

  // State and delay counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load a head delay (zero goes straight to READY), count it
  // down in WAIT, pop on fire.
  always_comb begin
    logic                    do_load;
    logic [p_delay_bits-1:0] ld_delay;
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_load  = 1'b0;
    ld_delay = q_head.delay;
    unique case (state_q)
      ST_IDLE:  do_load = ~q_empty;
      ST_WAIT: begin
        if (cnt_q == p_delay_bits'(1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - p_delay_bits'(1);
        end
      end
      ST_READY: begin
        if (fire) begin
          if (next_avail) begin
            do_load  = 1'b1;
            ld_delay = next_entry.delay;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    if (do_load) begin
      cnt_d   = ld_delay;
      state_d = (ld_delay == '0) ? ST_READY : ST_WAIT;
    end
  end

  // Saturating count of mismatches, calls without rdy and overflows.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= '0;
    else       err_q <= sat_add16(err_q, err_inc);
  end

  assign error_count_o = err_q;

endmodule

// File: tb/tb_test_callee.sv
// Directed plus randomized bench for test_callee. The reference model keeps
// the script as a queue and predicts rdy from "ready at cycle N" arithmetic.
module tb_test_callee;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] call_msg;
  logic [31:0] ret_msg;
  logic        en;
  logic        rdy;
  logic        done;
  logic [15:0] error_count;
  logic        push;
  logic [31:0] push_exp;
  logic [31:0] push_ret;
  logic [7:0]  push_delay;

  test_callee #(
    .p_depth      (DEPTH),
    .p_delay_bits (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .call_msg_i      (call_msg),
    .ret_msg_o       (ret_msg),
    .en_i            (en),
    .rdy_o           (rdy),
    .done_o          (done),
    .error_count_o   (error_count),
    .push_i          (push),
    .push_exp_call_i (push_exp),
    .push_ret_i      (push_ret),
    .push_delay_i    (push_delay)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] ret;
    int          d;
  } ment_t;

  ment_t mq[$];
  int    cyc    = 0;
  int    rdy_at = 0;
  int    merr   = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance one clock: apply the rules to the current inputs, then compare.
  task automatic tick();
    bit prdy, fire, was_empty, mrdy;
    int n;
    prdy = (mq.size() > 0) && (cyc >= rdy_at);
    n    = cyc + 1;
    if (rst) begin
      mq.delete();
      merr = 0;
    end else begin
      fire = en && prdy;
      if (en && !prdy) merr++;
      if (fire) begin
        if (call_msg !== mq[0].exp) merr++;
        void'(mq.pop_front());
        if (mq.size() > 0) rdy_at = n + mq[0].d;
      end
      if (push) begin
        if (mq.size() >= DEPTH) merr++;
        else begin
          was_empty = (mq.size() == 0);
          mq.push_back('{push_exp, push_ret, int'(push_delay)});
          if (was_empty) rdy_at = fire ? n + int'(push_delay) : n + int'(push_delay) + 1;
        end
      end
    end
    cyc = n;
    @(posedge clk);
    #1;
    mrdy = (mq.size() > 0) && (cyc >= rdy_at);
    chk("rdy", {31'b0, rdy}, {31'b0, mrdy});
    chk("done", {31'b0, done}, {31'b0, mq.size() == 0});
    chk("error_count", {16'b0, error_count}, merr);
    if (mrdy) chk("ret_msg", ret_msg, mq[0].ret);
  endtask

  task automatic add_call(input logic [31:0] e, input logic [31:0] r, input int d);
    push = 1'b1; push_exp = e; push_ret = r; push_delay = 8'(d);
    tick();
    push = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; push = 1'b0; call_msg = '0;
    push_exp = '0; push_ret = '0; push_delay = '0;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset: rdy low, done high, no errors.
    repeat (10) tick();
    chk("idle_err", {16'b0, error_count}, 32'd0);

    // Single delay-0 call: rdy the cycle after commit.
    add_call(32'h5, 32'hA, 0);
    chk("d0_rdy_commit", {31'b0, rdy}, 32'd0);
    tick();
    chk("d0_rdy", {31'b0, rdy}, 32'd1);
    chk("d0_ret", ret_msg, 32'hA);
    en = 1'b1; call_msg = 32'h5;
    tick();
    en = 1'b0;
    chk("d0_done", {31'b0, done}, 32'd1);
    chk("d0_err", {16'b0, error_count}, 32'd0);

    // Four delay-0 entries, called back to back.
    for (int i = 0; i < 4; i++) add_call(32'h100 + i, $urandom, 0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      call_msg = 32'h100 + i;
      tick();
    end
    en = 1'b0;
    chk("b2b_done", {31'b0, done}, 32'd1);
    chk("b2b_err", {16'b0, error_count}, 32'd0);

    // Delay 3 with en held through the wait: four violations, then a fire.
    do_reset();
    add_call(32'h33, 32'h44, 3);
    en = 1'b1; call_msg = 32'h33;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("d3_low", {31'b0, rdy}, {31'b0, i == 3});
    end
    tick();
    en = 1'b0;
    chk("d3_err", {16'b0, error_count}, 32'd4);
    chk("d3_done", {31'b0, done}, 32'd1);

    // Mismatched call still pops.
    do_reset();
    add_call(32'h7, 32'h70, 0);
    tick();
    en = 1'b1; call_msg = 32'h8;
    tick();
    en = 1'b0;
    chk("mm_err", {16'b0, error_count}, 32'd1);
    chk("mm_done", {31'b0, done}, 32'd1);

    // Maximum delay of 255.
    do_reset();
    add_call(32'h1, 32'h2, 255);
    repeat (256) tick();
    chk("dmax_rdy", {31'b0, rdy}, 32'd1);
    en = 1'b1; call_msg = 32'h1;
    tick();
    en = 1'b0;

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      push       = ($urandom_range(0, 2) == 0);
      push_exp   = $urandom;
      push_ret   = $urandom;
      push_delay = 8'($urandom_range(0, 3));
      en         = ($urandom_range(0, 1) == 1);
      call_msg   = (mq.size() > 0 && $urandom_range(0, 5) != 0) ? mq[0].exp : $urandom;
      tick();
    end
    push = 1'b0; en = 1'b0;

    // Overflow: 33 pushes into a 32-deep queue.
    do_reset();
    for (int i = 0; i < 33; i++) add_call($urandom, $urandom, 200);
    chk("ovf_err", {16'b0, error_count}, 32'd1);

    // Reset mid-queue, with a push during the reset cycle that must vanish.
    rst = 1'b1; push = 1'b1; push_exp = 32'h9; push_ret = 32'h9; push_delay = 8'd0;
    tick();
    rst = 1'b0; push = 1'b0;
    chk("rst_done", {31'b0, done}, 32'd1);
    chk("rst_rdy", {31'b0, rdy}, 32'd0);
    chk("rst_err", {16'b0, error_count}, 32'd0);
    repeat (3) tick();
    chk("rst_drop", {31'b0, done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
